fp16_mult_front_pipelined: RTL and testbench
============================================

FP16_MULT_FRONT_PIPELINED -- requirements
Module: fp16_mult_front_pipelined

Interface
REQ-001 Parameter N, default 16, FP operand width; only 16 (1 sign/5 exp/10 frac) is supported.
REQ-002 clk  in  1  clock; all registers update on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  operand pair a/b is valid this cycle.
REQ-005 in_ready  out  1  block accepts the operand pair this cycle.
REQ-006 a, b  in  16 each  FP16 operands.
REQ-007 out_valid  out  1  result fields are valid.
REQ-008 out_ready  in  1  downstream normalizer accepts the result.
REQ-009 sign_out  out  1  product sign.
REQ-010 mant_product  out  20  product mantissa; leading 1 at bit 19 or bit 18.
REQ-011 exp_sum  out  6  unsigned biased exponent before normalization.
REQ-012 flags  out  4  {nan, inf, zero, uflow}.

Function
REQ-013 The block is a 3-stage pipeline with fixed latency 3: S1 unpack, S2 partial products, S3 sum and output.
REQ-014 Advance = !out_valid || out_ready; all stages shift only when advance=1.
REQ-015 in_ready = advance; an input transfers on in_valid && in_ready.
REQ-016 Each stage holds a valid bit; a bubble (valid=0) propagates like data.
REQ-017 When out_valid=1 && out_ready=0, all outputs and stage contents hold stable.
REQ-018 S1: sign = a[15]^b[15]; ma = {1,a[9:0]}, mb = {1,b[9:0]} (11 bits); ea, eb raw.
REQ-019 S1 classification: exp=0 is zero, including subnormals (flush-to-zero); exp=31 with frac=0 is inf; exp=31 with frac!=0 is NaN.
REQ-020 S2: ma*mb computed as ma*mb[5:0] and (ma*mb[10:6])<<6, both registered.
REQ-021 S3: p22 = sum of the partials; mant_product = p22[21:2], truncated with no rounding.
REQ-022 Exponent: e7 = ea+eb-14, computed at 7 bits signed.
REQ-023 If e7 <= 0: uflow=1, exp_sum=0, mant_product=0.
REQ-024 Otherwise exp_sum = e7[5:0]; the maximum is 46, so no overflow is possible in 6 bits.
REQ-025 Flag priority: NaN operand, or inf*zero, gives nan=1 only.
REQ-026 Otherwise any inf operand gives inf=1; otherwise any zero operand gives zero=1.
REQ-027 When nan, inf or zero is set, mant_product=0, exp_sum=0 and uflow=0.
REQ-028 Sign is still produced for zero and inf results.
REQ-029 Simultaneous accept at S1 and drain at S3 in the same cycle is legal; throughput is 1 result per cycle.

Reset
REQ-030 On rst_n low, all stage valid bits clear immediately and out_valid=0.
REQ-031 During reset, sign_out, mant_product, exp_sum and flags all read 0.
REQ-032 Reset mid-operation discards all in-flight data; no result emerges for pre-reset inputs.
REQ-033 in_ready=1 from the first cycle after reset release.

Structure
REQ-034 Package fp16_pkg holds: FP16 field widths, EXP_BIAS=15, the flag bit-index constants, and a packed struct type for unpacked operands.
REQ-035 A single sub-module fp16_unpack, combinational, performs S1 classification; it is instantiated twice, once per operand.
REQ-036 Outputs connect directly to normalize-stage inputs mant_product[19:0] and exp_sum[5:0].

Verification
REQ-037 a=0x3C00, b=0x3C00 (1.0*1.0), out_ready=1 -> 3 cycles later: mant_product=0x40000, exp_sum=16, sign=0, flags=0.
REQ-038 a=0x4000, b=0xC200 (2*-3) -> mant_product=0x60000, exp_sum=18, sign=1, flags=0.
REQ-039 a=0x7C00, b=0x0000 -> nan=1, mant_product=0, exp_sum=0.
REQ-040 a=0x0400, b=0x0400 (e7=-12) -> uflow=1, exp_sum=0, mant_product=0.
REQ-041 Stream 8 back-to-back inputs with out_ready low for cycles 4-6 -> no loss or duplication, order kept, outputs stable while stalled, in_ready low while stalled.
REQ-042 Assert rst_n with 3 results in flight -> out_valid=0 immediately; no stale results appear after reset release.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the multiplier front end: field widths,
// exponent bias, flag bit positions and the unpacked-operand record.
package fp16_pkg;

   localparam int FP_W       = 16;
   localparam int EXP_W      = 5;
   localparam int FRAC_W     = 10;
   localparam int MANT_W     = FRAC_W + 1;        // hidden one restored
   localparam int EXP_BIAS   = 15;

   localparam int PP_LO_W    = MANT_W + 6;        // ma * mb[5:0]
   localparam int PP_HI_W    = MANT_W + 5;        // ma * mb[10:6]
   localparam int PROD_W     = 2 * MANT_W;        // full 22-bit product
   localparam int MANT_OUT_W = 20;
   localparam int EXP_OUT_W  = 6;
   localparam int FLAG_W     = 4;

   // Bit positions inside flags = {nan, inf, zero, uflow}
   localparam int FLAG_NAN   = 3;
   localparam int FLAG_INF   = 2;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_UFLOW = 0;

   // Subtracting one less than the bias keeps the exponent aligned with a
   // product whose leading one sits at bit 18 (1.x) or bit 19 (2.x or more).
   localparam logic signed [6:0] EXP_OFFSET = 7'(EXP_BIAS - 1);

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
      logic              is_zero;
      logic              is_inf;
      logic              is_nan;
   } fp16_unpacked_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational FP16 operand unpack: splits the fields, restores the hidden
// one and classifies the operand. Subnormals flush to zero.
module fp16_unpack
   import fp16_pkg::*;
(
   input  logic [FP_W-1:0] op_i,
   output fp16_unpacked_t  unp_o
);

   logic [EXP_W-1:0]  exp_field;
   logic [FRAC_W-1:0] frac_field;

   assign exp_field  = op_i[FP_W-2 -: EXP_W];
   assign frac_field = op_i[FRAC_W-1:0];

   // Field split and classification of one operand
   always_comb begin
      unp_o.sign    = op_i[FP_W-1];
      unp_o.exp     = exp_field;
      unp_o.mant    = {1'b1, frac_field};
      unp_o.is_zero = (exp_field == '0);
      unp_o.is_inf  = (exp_field == '1) && (frac_field == '0);
      unp_o.is_nan  = (exp_field == '1) && (frac_field != '0);
   end

endmodule

// File: rtl/fp16_mult_front_pipelined.sv
// FP16 multiplier front end, three stages with fixed latency 3:
//   S1 unpack/classify/exponent, S2 split partial products, S3 sum and output.
// The whole pipe advances together whenever the output is empty or drained,
// so a stalled output freezes every stage and bubbles travel like data.
// Only N = 16 is supported.
module fp16_mult_front_pipelined
   import fp16_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          a,
   input  logic [N-1:0]          b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sign_out,
   output logic [MANT_OUT_W-1:0] mant_product,
   output logic [EXP_OUT_W-1:0]  exp_sum,
   output logic [FLAG_W-1:0]     flags
);

   logic advance;

   // S1 combinational signals
   fp16_unpacked_t          unp_a, unp_b;
   logic signed [6:0]       e7;
   logic                    s1_sign_d;
   logic [EXP_OUT_W-1:0]    s1_exp_d;
   logic [FLAG_W-1:0]       s1_flags_d;

   // S1 registers
   logic                    s1_valid_q;
   logic                    s1_sign_q;
   logic [MANT_W-1:0]       s1_ma_q, s1_mb_q;
   logic [EXP_OUT_W-1:0]    s1_exp_q;
   logic [FLAG_W-1:0]       s1_flags_q;

   // S2 next-state and registers
   logic [PP_LO_W-1:0]      s2_pp_lo_d;
   logic [PROD_W-1:0]       s2_pp_hi_d;
   logic                    s2_valid_q;
   logic                    s2_sign_q;
   logic [PP_LO_W-1:0]      s2_pp_lo_q;
   logic [PROD_W-1:0]       s2_pp_hi_q;
   logic [EXP_OUT_W-1:0]    s2_exp_q;
   logic [FLAG_W-1:0]       s2_flags_q;

   // S3 next-state and output registers
   logic [PROD_W-1:0]       p22;
   logic [MANT_OUT_W-1:0]   s3_mant_d;
   logic                    s3_valid_q;
   logic                    s3_sign_q;
   logic [MANT_OUT_W-1:0]   s3_mant_q;
   logic [EXP_OUT_W-1:0]    s3_exp_q;
   logic [FLAG_W-1:0]       s3_flags_q;

   assign advance  = !s3_valid_q || out_ready;
   assign in_ready = advance;

   fp16_unpack u_unpack_a (.op_i(a), .unp_o(unp_a));
   fp16_unpack u_unpack_b (.op_i(b), .unp_o(unp_b));

   // S1: sign, flag priority and exponent sum; special results force exp to 0
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      s1_flags_d = '0;
      s1_exp_d   = '0;
      s1_sign_d  = unp_a.sign ^ unp_b.sign;
      e7         = $signed({2'b00, unp_a.exp}) + $signed({2'b00, unp_b.exp})
                   - EXP_OFFSET;

      if (unp_a.is_nan || unp_b.is_nan ||
          (unp_a.is_inf && unp_b.is_zero) || (unp_a.is_zero && unp_b.is_inf)) begin
         s1_flags_d[FLAG_NAN] = 1'b1;
      end else if (unp_a.is_inf || unp_b.is_inf) begin
         s1_flags_d[FLAG_INF] = 1'b1;
      end else if (unp_a.is_zero || unp_b.is_zero) begin
         s1_flags_d[FLAG_ZERO] = 1'b1;
      end else if (e7 <= 7'sd0) begin
         s1_flags_d[FLAG_UFLOW] = 1'b1;
      end else begin
         s1_exp_d = e7[EXP_OUT_W-1:0];
      end
   end

   // S1 register stage
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset too, because outputs must read
      // zero while reset is held, not only the valid bits.
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_ma_q    <= '0;
         s1_mb_q    <= '0;
         s1_exp_q   <= '0;
         s1_flags_q <= '0;
      end else if (advance) begin
         // NOTE: non-blocking assignments so every stage samples the values
         // its predecessor held before this edge.
         s1_valid_q <= in_valid;
         s1_sign_q  <= s1_sign_d;
         s1_ma_q    <= unp_a.mant;
         s1_mb_q    <= unp_b.mant;
         s1_exp_q   <= s1_exp_d;
         s1_flags_q <= s1_flags_d;
      end
   end

   // S2: split multiply into a low 6-bit and a high 5-bit slice of mb
   always_comb begin
      logic [PP_HI_W-1:0] pp_hi_raw;
      s2_pp_lo_d = {{(PP_LO_W-MANT_W){1'b0}}, s1_ma_q} *
                   {{(PP_LO_W-6){1'b0}}, s1_mb_q[5:0]};
      pp_hi_raw  = {{(PP_HI_W-MANT_W){1'b0}}, s1_ma_q} *
                   {{(PP_HI_W-5){1'b0}}, s1_mb_q[10:6]};
      s2_pp_hi_d = {pp_hi_raw, 6'b0};
   end

   // S2 register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_pp_lo_q <= '0;
         s2_pp_hi_q <= '0;
         s2_exp_q   <= '0;
         s2_flags_q <= '0;
      end else if (advance) begin
         s2_valid_q <= s1_valid_q;
         s2_sign_q  <= s1_sign_q;
         s2_pp_lo_q <= s2_pp_lo_d;
         s2_pp_hi_q <= s2_pp_hi_d;
         s2_exp_q   <= s1_exp_q;
         s2_flags_q <= s1_flags_q;
      end
   end

   // S3: sum partials, truncate two LSBs, zero the mantissa for any flag
   always_comb begin
      p22       = {{(PROD_W-PP_LO_W){1'b0}}, s2_pp_lo_q} + s2_pp_hi_q;
      s3_mant_d = (|s2_flags_q) ? '0 : p22[PROD_W-1:2];
   end

   // S3 output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_q <= 1'b0;
         s3_sign_q  <= 1'b0;
         s3_mant_q  <= '0;
         s3_exp_q   <= '0;
         s3_flags_q <= '0;
      end else if (advance) begin
         s3_valid_q <= s2_valid_q;
         s3_sign_q  <= s2_sign_q;
         s3_mant_q  <= s3_mant_d;
         s3_exp_q   <= s2_exp_q;
         s3_flags_q <= s2_flags_q;
      end
   end

   assign out_valid    = s3_valid_q;
   assign sign_out     = s3_sign_q;
   assign mant_product = s3_mant_q;
   assign exp_sum      = s3_exp_q;
   assign flags        = s3_flags_q;

endmodule

// File: tb/tb_fp16_mult_front_pipelined.sv
// Self-checking bench for fp16_mult_front_pipelined: directed vectors with
// literal expectations, a back-to-back stream with an output stall, and a
// mid-flight reset. A monitor compares every valid output to a field-level
// model of FP16 multiplication kept in an in-order queue.
module tb_fp16_mult_front_pipelined;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic        sign_out;
   logic [19:0] mant_product;
   logic [5:0]  exp_sum;
   logic [3:0]  flags;

   int n_checks  = 0;
   int n_errs    = 0;
   int n_results = 0;

   logic [30:0] exp_q[$];   // {sign, flags, exp_sum, mant_product}

   fp16_mult_front_pipelined #(.N(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .sign_out(sign_out), .mant_product(mant_product),
      .exp_sum(exp_sum), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Field-level FP16 product: real mantissas 1.f multiplied as integers,
   // unbiased exponents added, then re-biased for a leading one at bit 18.
   function automatic logic [30:0] model(input logic [15:0] x, input logic [15:0] y);
      int ex = int'(x[14:10]);
      int ey = int'(y[14:10]);
      int fx = int'(x[9:0]);
      int fy = int'(y[9:0]);
      logic s = x[15] ^ y[15];
      bit zx = (ex == 0), zy = (ey == 0);
      bit ix = (ex == 31) && (fx == 0), iy = (ey == 31) && (fy == 0);
      bit nx = (ex == 31) && (fx != 0), ny = (ey == 31) && (fy != 0);
      int e = (ex - 15) + (ey - 15) + 16;
      int p = (1024 + fx) * (1024 + fy);
      if (nx || ny || (ix && zy) || (zx && iy)) return {s, 4'b1000, 6'd0, 20'd0};
      if (ix || iy)                             return {s, 4'b0100, 6'd0, 20'd0};
      if (zx || zy)                             return {s, 4'b0010, 6'd0, 20'd0};
      if (e <= 0)                               return {s, 4'b0001, 6'd0, 20'd0};
      return {s, 4'b0000, 6'(e), 20'(p / 4)};
   endfunction

   // In-flight results are lost on reset
   always @(negedge rst_n) exp_q.delete();

   // Monitor: check outputs and handshake, pop on transfer, push on accept
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready_eq_advance", 32'(in_ready), 32'(!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               check("out_fields", 32'({sign_out, flags, exp_sum, mant_product}), 32'(exp_q[0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_results++;
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b));
      end
   end

   // One isolated vector: latency and literal field expectations
   task automatic run_vec(input string nm, input logic [15:0] va, input logic [15:0] vb,
                          input logic es, input logic [19:0] em, input logic [5:0] ee,
                          input logic [3:0] ef);
      int  lat;
      bit  seen;
      @(posedge clk); #1;
      a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      if (!seen) begin
         check({nm, "_timeout"}, 32'(out_valid), 32'd1);
      end else begin
         check({nm, "_latency"}, 32'(lat), 32'd3);
         check({nm, "_sign"}, 32'(sign_out), 32'(es));
         check({nm, "_mant"}, 32'(mant_product), 32'(em));
         check({nm, "_exp"}, 32'(exp_sum), 32'(ee));
         check({nm, "_flags"}, 32'(flags), 32'(ef));
      end
   endtask

   logic [15:0] sva [8] = '{16'h3C00, 16'h4000, 16'h7C00, 16'h0400,
                            16'h7BFF, 16'hFC00, 16'h8001, 16'h3555};
   logic [15:0] svb [8] = '{16'h3C00, 16'hC200, 16'h0000, 16'h0400,
                            16'h7BFF, 16'h4000, 16'h3C00, 16'hB555};

   initial begin
      int idx, base, seen_after;
      bit fire;

      // Reset state
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fields", 32'({sign_out, flags, exp_sum, mant_product}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors with hand-computed results
      run_vec("one_x_one", 16'h3C00, 16'h3C00, 1'b0, 20'h40000, 6'd16, 4'b0000);
      run_vec("two_x_m3",  16'h4000, 16'hC200, 1'b1, 20'h60000, 6'd18, 4'b0000);
      run_vec("inf_x_0",   16'h7C00, 16'h0000, 1'b0, 20'h00000, 6'd0,  4'b1000);
      run_vec("uflow",     16'h0400, 16'h0400, 1'b0, 20'h00000, 6'd0,  4'b0001);
      run_vec("max_x_max", 16'h7BFF, 16'h7BFF, 1'b0, 20'hFFC00, 6'd46, 4'b0000);
      run_vec("minf_x_2",  16'hFC00, 16'h4000, 1'b1, 20'h00000, 6'd0,  4'b0100);
      run_vec("subn_x_1",  16'h8001, 16'h3C00, 1'b1, 20'h00000, 6'd0,  4'b0010);
      run_vec("nan_x_1",   16'h7E00, 16'h3C00, 1'b0, 20'h00000, 6'd0,  4'b1000);

      // Drain the last directed result
      @(posedge clk); #1;

      // Eight back-to-back inputs, output stalled for cycles 4-6
      base = n_results;
      idx  = 0;
      for (int j = 0; j < 40; j++) begin
         out_ready = !(j >= 4 && j <= 6);
         in_valid  = (idx < 8);
         a = (idx < 8) ? sva[idx] : 16'h0;
         b = (idx < 8) ? svb[idx] : 16'h0;
         @(negedge clk);
         fire = in_valid && in_ready;
         if (j >= 4 && j <= 6) check("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         if (fire) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_accepted", 32'(idx), 32'd8);
      check("stream_results", 32'(n_results - base), 32'd8);
      check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

      // Three results in flight, then asynchronous reset
      for (int i = 0; i < 3; i++) begin
         a = sva[i]; b = svb[i]; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_fields", 32'({sign_out, flags, exp_sum, mant_product}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      seen_after = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) seen_after++;
         @(posedge clk); #1;
      end
      check("midrst_no_stale", 32'(seen_after), 32'd0);

      // A fresh result after reset still comes through correctly
      run_vec("post_rst", 16'h4000, 16'hC200, 1'b1, 20'h60000, 6'd18, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
      $fatal(1, "watchdog");
   end

endmodule
